// File: rtl/convclk_grayffrd_fwft.sv
// Read-side controller of the dual-clock Gray-pointer FIFO with a first-word-fall-through output.
// Synchronizes the far-end write pointer, issues RAM reads and buffers returning words in a 2-entry skid buffer.
module convclk_grayffrd_fwft #(
    parameter int ADDRB = 4,
    parameter int DATAW = 8
) (
    input  logic             wrclk,
    input  logic             wrrst_,
    input  logic             fifoflush,
    input  logic [ADDRB:0]   wrpnt_gray,
    output logic [ADDRB:0]   rdpnt_gray,
    output logic             read,
    output logic [ADDRB-1:0] rdaddr,
    input  logic [DATAW-1:0] rddata,
    output logic             dout_vld,
    output logic [DATAW-1:0] dout,
    input  logic             dout_rdy,
    output logic             empty,
    output logic [ADDRB:0]   rdfifolen
);

    localparam int PW = ADDRB + 1;

    logic [PW-1:0]    wp1;
    logic [PW-1:0]    wp2;
    logic [PW-1:0]    wp_bin;
    logic [PW-1:0]    rdpnt_bin;

    logic             inflight;
    logic [1:0]       bufcnt;
    logic [1:0]       bufcnt_nxt;
    logic [DATAW-1:0] head;
    logic [DATAW-1:0] head_nxt;
    logic [DATAW-1:0] tail;
    logic [DATAW-1:0] tail_nxt;
    logic             pop;
    logic [2:0]       occ;

    // Two-flop synchronizer for the Gray write pointer from the producer domain.
    always_ff @(posedge wrclk or negedge wrrst_) begin
        if (!wrrst_) begin
            wp1 <= '0;
            wp2 <= '0;
        end else begin
            wp1 <= wrpnt_gray;
            wp2 <= wp1;
        end
    end

    always_comb begin
        wp_bin = '0;
        for (int i = 0; i < PW; i++) begin
            wp_bin[i] = ^(wp2 >> i);
        end
    end

    assign empty     = (rdpnt_bin == wp_bin);
    assign rdfifolen = wp_bin - rdpnt_bin;
    assign rdaddr    = rdpnt_bin[ADDRB-1:0];

    // Output handshake: a word transfers on every wrclk edge where dout_vld and dout_rdy are
    // both high; once dout_vld rises, dout holds its value until that transfer happens.
    assign dout_vld = (bufcnt != 2'd0);
    assign dout     = head;
    assign pop      = dout_vld & dout_rdy;

    // Words already owned by the output stage after this edge's pop; a read is issued only
    // if its data will still find a free slot when it returns.
    assign occ  = {1'b0, bufcnt} + {2'b00, inflight} - {2'b00, pop};
    assign read = ~empty & ~fifoflush & (occ < 3'd2);

    always_comb begin
        bufcnt_nxt = bufcnt;
        head_nxt   = head;
        tail_nxt   = tail;
        case ({inflight, pop})
            2'b01: begin
                head_nxt   = tail;
                bufcnt_nxt = bufcnt - 2'd1;
            end
            2'b10: begin
                if (bufcnt == 2'd0) begin
                    head_nxt = rddata;
                end else begin
                    tail_nxt = rddata;
                end
                bufcnt_nxt = bufcnt + 2'd1;
            end
            2'b11: begin
                // Capture and pop together: count unchanged, the tail advances before the new word lands.
                if (bufcnt == 2'd1) begin
                    head_nxt = rddata;
                end else begin
                    head_nxt = tail;
                    tail_nxt = rddata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wrclk or negedge wrrst_) begin
        if (!wrrst_) begin
            rdpnt_bin  <= '0;
            rdpnt_gray <= '0;
            inflight   <= 1'b0;
            bufcnt     <= 2'd0;
            head       <= '0;
            tail       <= '0;
        end else begin
            // The Gray copy follows the binary pointer one cycle late, flush included.
            rdpnt_gray <= rdpnt_bin ^ (rdpnt_bin >> 1);
            if (fifoflush) begin
                rdpnt_bin <= '0;
                inflight  <= 1'b0;
                bufcnt    <= 2'd0;
                head      <= '0;
                tail      <= '0;
            end else begin
                if (read) begin
                    rdpnt_bin <= rdpnt_bin + 1'b1;
                end
                inflight <= read;
                bufcnt   <= bufcnt_nxt;
                head     <= head_nxt;
                tail     <= tail_nxt;
            end
        end
    end

endmodule

// File: tb/tb_convclk_grayffrd_fwft.sv
// Bench for convclk_grayffrd_fwft: models the write side and RAM, checks the output stream
// against a queue of written words plus latency, backpressure, wrap, flush and reset cases.
module tb_convclk_grayffrd_fwft;

    localparam int ADDRB = 4;
    localparam int DATAW = 8;

    logic             wrclk;
    logic             wrrst_;
    logic             fifoflush;
    logic [ADDRB:0]   wrpnt_gray;
    logic [ADDRB:0]   rdpnt_gray;
    logic             read;
    logic [ADDRB-1:0] rdaddr;
    logic [DATAW-1:0] rddata;
    logic             dout_vld;
    logic [DATAW-1:0] dout;
    logic             dout_rdy;
    logic             empty;
    logic [ADDRB:0]   rdfifolen;

    convclk_grayffrd_fwft #(.ADDRB(ADDRB), .DATAW(DATAW)) dut (
        .wrclk     (wrclk),
        .wrrst_    (wrrst_),
        .fifoflush (fifoflush),
        .wrpnt_gray(wrpnt_gray),
        .rdpnt_gray(rdpnt_gray),
        .read      (read),
        .rdaddr    (rdaddr),
        .rddata    (rddata),
        .dout_vld  (dout_vld),
        .dout      (dout),
        .dout_rdy  (dout_rdy),
        .empty     (empty),
        .rdfifolen (rdfifolen)
    );

    // clock / reset
    initial wrclk = 1'b0;
    always #5 wrclk = ~wrclk;

    // RAM model: synchronous read, data one cycle after read
    logic [DATAW-1:0] mem [16];
    initial rddata = '0;
    always @(posedge wrclk) if (read) rddata <= mem[rdaddr];

    // scoreboard state
    logic [DATAW-1:0] exp_q[$];
    logic [ADDRB:0]   wbin;
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    int pop_cnt  = 0;
    int first_pop = -1;
    int last_pop  = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [ADDRB:0] to_gray(input logic [ADDRB:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDRB:0] from_gray(input logic [ADDRB:0] g);
        logic [ADDRB:0] b;
        for (int i = 0; i <= ADDRB; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    // write-side model: store word in RAM, advance pointer, publish Gray pointer
    task automatic push_word(input logic [DATAW-1:0] d);
        mem[wbin[ADDRB-1:0]] = d;
        exp_q.push_back(d);
        wbin = wbin + 1'b1;
        wrpnt_gray = to_gray(wbin);
    endtask

    function automatic logic has_room();
        logic [ADDRB:0] occ5;
        occ5 = wbin - from_gray(rdpnt_gray);
        return (occ5 < 5'd16);
    endfunction

    // one cycle: monitor at negedge, then advance past the next edge
    task automatic tick();
        logic [DATAW-1:0] e;
        @(negedge wrclk);
        chk("rd_while_empty", 32'(read & empty), 32'd0);
        chk("len_max", 32'(rdfifolen <= 5'd16), 32'd1);
        if (read) rd_cnt++;
        if (dout_vld && dout_rdy) begin
            chk("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("dout", 32'(dout), 32'(e));
            end
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            pop_cnt++;
        end
        @(posedge wrclk);
        cyc++;
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        wbin = '0;
        wrpnt_gray = '0;
        rd_cnt = 0;
        pop_cnt = 0;
        first_pop = -1;
        last_pop = -1;
    endtask

    task automatic do_reset();
        wrrst_ = 1'b0;
        fifoflush = 1'b0;
        dout_rdy = 1'b0;
        clear_model();
        repeat (2) @(posedge wrclk);
        #1;
        wrrst_ = 1'b1;
    endtask

    initial begin
        int first_vld;
        int edges;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        do_reset();

        // reset values and idle
        chk("rst_rdaddr", 32'(rdaddr), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_len", 32'(rdfifolen), 32'd0);
        for (int i = 0; i < 20; i++) begin
            chk("idle_empty", 32'(empty), 32'd1);
            chk("idle_read", 32'(read), 32'd0);
            chk("idle_vld", 32'(dout_vld), 32'd0);
            chk("idle_rdgray", 32'(rdpnt_gray), 32'd0);
            tick();
        end

        // streaming 5 words, dout_rdy high
        dout_rdy = 1'b1;
        first_vld = -1;
        edges = 0;
        for (int i = 0; i < 14; i++) begin
            if (wbin < 5) push_word(8'hA0 + 8'(wbin));
            tick();
            edges++;
            if (dout_vld && first_vld < 0) first_vld = edges;
        end
        chk("first_vld_edges", 32'(first_vld), 32'd4);
        chk("s_pops", 32'(pop_cnt), 32'd5);
        chk("s_no_gap", 32'(last_pop - first_pop), 32'd4);
        chk("s_rdgray", 32'(rdpnt_gray), 32'b00111);
        chk("s_empty", 32'(empty), 32'd1);

        // backpressure
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (wbin < 5) push_word(8'hA0 + 8'(wbin));
            tick();
            if (dout_vld) chk("bp_hold", 32'(dout), 32'hA0);
        end
        chk("bp_reads", 32'(rd_cnt), 32'd2);
        chk("bp_vld", 32'(dout_vld), 32'd1);
        chk("bp_len", 32'(rdfifolen), 32'd3);
        dout_rdy = 1'b1;
        for (int i = 0; i < 30 && pop_cnt < 5; i++) tick();
        chk("bp_drain", 32'(pop_cnt), 32'd5);

        // wrap: 40 words through depth 16 with random backpressure
        do_reset();
        for (int i = 0; i < 3000 && pop_cnt < 40; i++) begin
            dout_rdy = 1'($urandom_range(0, 1));
            if (wbin < 40 - 32 + 32 && (pop_cnt + exp_q.size()) < 40 && has_room() && $urandom_range(0, 3) != 0)
                push_word(8'($urandom_range(0, 255)));
            tick();
        end
        chk("wrap_pops", 32'(pop_cnt), 32'd40);
        chk("wrap_q_empty", 32'(exp_q.size()), 32'd0);
        chk("wrap_rdgray", 32'(rdpnt_gray), 32'(to_gray(5'd8)));

        // flush with a word buffered and another in flight
        do_reset();
        for (int i = 0; i < 20 && rd_cnt < 2; i++) begin
            if (wbin < 5) push_word(8'hA0 + 8'(wbin));
            tick();
        end
        chk("fl_setup_reads", 32'(rd_cnt), 32'd2);
        chk("fl_setup_vld", 32'(dout_vld), 32'd1);
        fifoflush = 1'b1;
        clear_model();
        chk("fl_noread", 32'(read), 32'd0);
        tick();
        chk("fl_vld", 32'(dout_vld), 32'd0);
        chk("fl_rdaddr", 32'(rdaddr), 32'd0);
        tick();
        chk("fl_rdgray", 32'(rdpnt_gray), 32'd0);
        fifoflush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fl_discard", 32'(dout_vld), 32'd0);
            chk("fl_empty", 32'(empty), 32'd1);
        end
        dout_rdy = 1'b1;
        for (int i = 0; i < 20 && pop_cnt < 3; i++) begin
            if (wbin < 3) push_word(8'h50 + 8'(wbin));
            tick();
        end
        chk("fl_restart", 32'(pop_cnt), 32'd3);

        // asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 20 && !dout_vld; i++) begin
            if (wbin < 3) push_word(8'h30 + 8'(wbin));
            tick();
        end
        chk("ar_setup", 32'(dout_vld), 32'd1);
        #2;
        wrrst_ = 1'b0;
        #1;
        chk("ar_vld", 32'(dout_vld), 32'd0);
        chk("ar_dout", 32'(dout), 32'd0);
        chk("ar_read", 32'(read), 32'd0);
        chk("ar_empty", 32'(empty), 32'd1);
        chk("ar_len", 32'(rdfifolen), 32'd0);
        chk("ar_rdgray", 32'(rdpnt_gray), 32'd0);
        chk("ar_rdaddr", 32'(rdaddr), 32'd0);
        do_reset();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
